// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch sequencer.
package instr_fetch_pkg;

  localparam int ADDR_W_DEF    = 24;
  localparam int INSTR_LEN_MAX = 4;
  localparam int LEN_W         = $clog2(INSTR_LEN_MAX + 1);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_EXT,
    FETCH_IMM0,
    FETCH_IMM1,
    HOLD
  } fetch_state_e;

  function automatic logic is_fetch(fetch_state_e s);
    return s != HOLD;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus, decoder, redirect and execute-side handshake signals of instr_fetch.
// instr_pc exists only when INSTR_FETCH_PC_OUT_EN is defined.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_req;
  logic              bus_ack;
  logic [7:0]        bus_data;
  logic [7:0]        dec_opcode;
  logic [7:0]        dec_opext;
  logic              dec_need_opext;
  logic              dec_need_imm;
  logic              dec_imm_size;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_new;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_opcode;
  logic [7:0]        instr_opext;
  logic [15:0]       instr_imm;
  logic [LEN_W-1:0]  instr_len;
`ifdef INSTR_FETCH_PC_OUT_EN
  logic [ADDR_W-1:0] instr_pc;
`endif

  modport master (
`ifdef INSTR_FETCH_PC_OUT_EN
    output instr_pc,
`endif
    output bus_addr, bus_req, dec_opcode, dec_opext,
    output instr_valid, instr_opcode, instr_opext, instr_imm, instr_len,
    input  bus_ack, bus_data, dec_need_opext, dec_need_imm, dec_imm_size,
    input  pc_load, pc_new, instr_ready
  );

  modport slave (
`ifdef INSTR_FETCH_PC_OUT_EN
    input  instr_pc,
`endif
    input  bus_addr, bus_req, dec_opcode, dec_opext,
    input  instr_valid, instr_opcode, instr_opext, instr_imm, instr_len,
    output bus_ack, bus_data, dec_need_opext, dec_need_imm, dec_imm_size,
    output pc_load, pc_new, instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Byte-serial S1C88 instruction fetch: opcode, optional ext byte, imm8/imm16.
// Define INSTR_FETCH_PC_OUT_EN to add instr_pc (address of the opcode byte).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset_n,
  instr_fetch_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        opext_q, opext_d;
  logic [15:0]       imm_q, imm_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              imm_size_q, imm_size_d;
  logic              bus_req_q, bus_req_d;
  logic              valid_q, valid_d;
  logic              ack;
`ifdef INSTR_FETCH_PC_OUT_EN
  logic [ADDR_W-1:0] pc_op_q, pc_op_d;
`endif

  assign ack = bus_req_q & bus.bus_ack;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    opext_d    = opext_q;
    imm_d      = imm_q;
    len_d      = len_q;
    imm_size_d = imm_size_q;
`ifdef INSTR_FETCH_PC_OUT_EN
    pc_op_d    = pc_op_q;
`endif
    // A redirect wins over any ack or handshake in the same cycle.
    if (bus.pc_load) begin
      pc_d    = bus.pc_new;
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: if (ack) begin
          pc_d       = pc_q + ADDR_W'(1);
          opcode_d   = bus.bus_data;
          opext_d    = 8'h00;
          imm_d      = 16'h0000;
          len_d      = LEN_W'(1);
          imm_size_d = bus.dec_imm_size;
`ifdef INSTR_FETCH_PC_OUT_EN
          pc_op_d    = pc_q;
`endif
          if (bus.dec_need_opext)    state_d = FETCH_EXT;
          else if (bus.dec_need_imm) state_d = FETCH_IMM0;
          else                       state_d = HOLD;
        end
        FETCH_EXT: if (ack) begin
          pc_d       = pc_q + ADDR_W'(1);
          opext_d    = bus.bus_data;
          len_d      = len_q + LEN_W'(1);
          imm_size_d = bus.dec_imm_size;
          state_d    = bus.dec_need_imm ? FETCH_IMM0 : HOLD;
        end
        FETCH_IMM0: if (ack) begin
          pc_d    = pc_q + ADDR_W'(1);
          imm_d   = {8'h00, bus.bus_data};
          len_d   = len_q + LEN_W'(1);
          state_d = imm_size_q ? FETCH_IMM1 : HOLD;
        end
        FETCH_IMM1: if (ack) begin
          pc_d        = pc_q + ADDR_W'(1);
          imm_d[15:8] = bus.bus_data;
          len_d       = len_q + LEN_W'(1);
          state_d     = HOLD;
        end
        HOLD: if (bus.instr_ready) state_d = FETCH_OP;
        default: state_d = FETCH_OP;
      endcase
    end
    bus_req_d = is_fetch(state_d);
    valid_d   = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= FETCH_OP;
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      opext_q    <= 8'h00;
      imm_q      <= 16'h0000;
      len_q      <= '0;
      imm_size_q <= 1'b0;
      bus_req_q  <= 1'b0;
      valid_q    <= 1'b0;
`ifdef INSTR_FETCH_PC_OUT_EN
      pc_op_q    <= RESET_PC;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      opext_q    <= opext_d;
      imm_q      <= imm_d;
      len_q      <= len_d;
      imm_size_q <= imm_size_d;
      bus_req_q  <= bus_req_d;
      valid_q    <= valid_d;
`ifdef INSTR_FETCH_PC_OUT_EN
      pc_op_q    <= pc_op_d;
`endif
    end
  end

  // The decoder sees the byte on the bus in its own ack cycle, so it adds no latency.
  assign bus.dec_opcode   = (state_q == FETCH_OP)  ? bus.bus_data : opcode_q;
  assign bus.dec_opext    = (state_q == FETCH_EXT) ? bus.bus_data : opext_q;
  assign bus.bus_addr     = pc_q;
  assign bus.bus_req      = bus_req_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr_opcode = opcode_q;
  assign bus.instr_opext  = opext_q;
  assign bus.instr_imm    = imm_q;
  assign bus.instr_len    = len_q;
`ifdef INSTR_FETCH_PC_OUT_EN
  assign bus.instr_pc     = pc_op_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory responder, table decoder stub, monitor.
module tb_instr_fetch;

  localparam int AW = 24;

  typedef struct {
    logic [7:0]    op;
    logic [7:0]    ext;
    logic [15:0]   imm;
    logic [2:0]    len;
    logic [AW-1:0] pc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  int     vectors = 0;
  int     fails = 0;
  int     ack_delay = 0;
  exp_t   sb[$];
  logic [7:0] mem [int];

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW)) bif ();

  instr_fetch #(.ADDR_W(AW), .RESET_PC(24'h000000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.master)
  );

  // Decoder stub: 01=imm8, 02=imm16, CE=ext prefix (10:imm16, 30:imm8, other:none)
  always_comb begin
    bif.dec_need_opext = 1'b0;
    bif.dec_need_imm   = 1'b0;
    bif.dec_imm_size   = 1'b0;
    case (bif.dec_opcode)
      8'h01: bif.dec_need_imm = 1'b1;
      8'h02: begin bif.dec_need_imm = 1'b1; bif.dec_imm_size = 1'b1; end
      8'hCE: begin
        bif.dec_need_opext = 1'b1;
        case (bif.dec_opext)
          8'h10: begin bif.dec_need_imm = 1'b1; bif.dec_imm_size = 1'b1; end
          8'h30: bif.dec_need_imm = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  function automatic logic [7:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_instr(input logic [7:0] op, input logic [7:0] ext,
                              input logic [15:0] imm, input logic [2:0] len,
                              input logic [AW-1:0] pc);
    exp_t e;
    e.op = op; e.ext = ext; e.imm = imm; e.len = len; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic redirect(input logic [AW-1:0] a);
    @(negedge clk);
    bif.pc_load = 1'b1;
    bif.pc_new  = a;
    @(negedge clk);
    bif.pc_load = 1'b0;
  endtask

  task automatic accept();
    int n;
    n = 0;
    while (!bif.instr_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bif.instr_valid) begin
      vectors++;
      fails++;
      $display("FAIL accept_timeout: got no instr_valid expected instr_valid within 200 cycles");
    end else begin
      bif.instr_ready = 1'b1;
      @(negedge clk);
      bif.instr_ready = 1'b0;
    end
  endtask

  // Memory responder: ack after ack_delay waiting cycles, address must hold while waiting.
  initial begin
    int wait_cnt;
    logic [AW-1:0] held_addr;
    wait_cnt  = 0;
    held_addr = '0;
    bif.bus_ack  = 1'b0;
    bif.bus_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n && bif.bus_req) begin
        if (wait_cnt == 0) held_addr = bif.bus_addr;
        else chk("addr_stable", 32'(bif.bus_addr), 32'(held_addr));
        if (wait_cnt >= ack_delay) begin
          bif.bus_ack  = 1'b1;
          bif.bus_data = rd(int'(bif.bus_addr));
          wait_cnt     = 0;
        end else begin
          bif.bus_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bif.bus_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Monitor: compare each accepted instruction against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && bif.instr_valid && bif.instr_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_instr: got opcode %h expected no instruction", bif.instr_opcode);
        end else begin
          e = sb.pop_front();
          $display("instr op=%h ext=%h imm=%h len=%0d", bif.instr_opcode, bif.instr_opext,
                   bif.instr_imm, bif.instr_len);
          chk("instr_opcode", 32'(bif.instr_opcode), 32'(e.op));
          chk("instr_opext",  32'(bif.instr_opext),  32'(e.ext));
          chk("instr_imm",    32'(bif.instr_imm),    32'(e.imm));
          chk("instr_len",    32'(bif.instr_len),    32'(e.len));
`ifdef INSTR_FETCH_PC_OUT_EN
          chk("instr_pc",     32'(bif.instr_pc),     32'(e.pc));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.pc_load     = 1'b0;
    bif.pc_new      = '0;
    bif.instr_ready = 1'b0;
    mem[1] = 8'hCE; mem[2] = 8'h10; mem[3] = 8'h34; mem[4] = 8'h12;
    mem[5] = 8'hCE; mem[6] = 8'h20;
    mem[7] = 8'h02; mem[8] = 8'h78; mem[9] = 8'h56;
    mem[32'h100] = 8'h01; mem[32'h101] = 8'hAB;
    mem[32'h300] = 8'h02; mem[32'h301] = 8'h11; mem[32'h302] = 8'h22;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req",  32'(bif.bus_req), 32'd0);
    chk("rst_valid",    32'(bif.instr_valid), 32'd0);
    chk("rst_opcode",   32'(bif.instr_opcode), 32'd0);
    chk("rst_opext",    32'(bif.instr_opext), 32'd0);
    chk("rst_imm",      32'(bif.instr_imm), 32'd0);
    chk("rst_len",      32'(bif.instr_len), 32'd0);
`ifdef INSTR_FETCH_PC_OUT_EN
    chk("rst_instr_pc", 32'(bif.instr_pc), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_req",  32'(bif.bus_req), 32'd1);
    chk("first_addr", 32'(bif.bus_addr), 32'd0);

    // 1-byte NOP at RESET_PC, valid one cycle after its ack
    expect_instr(8'h00, 8'h00, 16'h0000, 3'd1, 24'h000000);
    @(negedge clk);
    chk("valid_1cyc", 32'(bif.instr_valid), 32'd1);
    accept();
    chk("next_addr_1", 32'(bif.bus_addr), 32'd1);

    // CE 10 34 12: ext + imm16, 4 bytes
    expect_instr(8'hCE, 8'h10, 16'h1234, 3'd4, 24'h000001);
    accept();
    chk("next_addr_5", 32'(bif.bus_addr), 32'd5);

    // ext without imm, then imm16 without ext
    expect_instr(8'hCE, 8'h20, 16'h0000, 3'd2, 24'h000005);
    expect_instr(8'h02, 8'h00, 16'h5678, 3'd3, 24'h000007);
    accept();
    accept();

    // Slow bus, execute stage stalls for 5 cycles
    repeat (3) @(negedge clk);
    ack_delay = 3;
    expect_instr(8'h01, 8'h00, 16'h00AB, 3'd2, 24'h000100);
    redirect(24'h000100);
    for (int i = 0; i < 100 && !bif.instr_valid; i++) @(negedge clk);
    chk("slow_valid", 32'(bif.instr_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid",  32'(bif.instr_valid), 32'd1);
      chk("hold_opcode", 32'(bif.instr_opcode), 32'h01);
      chk("hold_imm",    32'(bif.instr_imm), 32'h00AB);
      chk("hold_len",    32'(bif.instr_len), 32'd2);
      chk("hold_no_req", 32'(bif.bus_req), 32'd0);
      @(negedge clk);
    end
    accept();
    ack_delay = 0;
    repeat (10) @(negedge clk);

    // Redirect in the imm0 ack cycle discards the byte and the instruction
    expect_instr(8'h00, 8'h00, 16'h0000, 3'd1, 24'h001200);
    redirect(24'h000300);
    for (int i = 0; i < 20 && bif.bus_addr != 24'h000301; i++) @(negedge clk);
    chk("at_imm0", 32'(bif.bus_addr), 32'h301);
    bif.pc_load = 1'b1;
    bif.pc_new  = 24'h001200;
    @(negedge clk);
    bif.pc_load = 1'b0;
    chk("redir_addr",  32'(bif.bus_addr), 32'h1200);
    chk("redir_req",   32'(bif.bus_req), 32'd1);
    chk("redir_valid", 32'(bif.instr_valid), 32'd0);
    accept();

    // PC wraps from 0xFFFFFF to 0
    expect_instr(8'h00, 8'h00, 16'h0000, 3'd1, 24'hFFFFFF);
    redirect(24'hFFFFFF);
    accept();
    chk("wrap_addr", 32'(bif.bus_addr), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Byte-serial instruction fetch sequencer for the S1C88 core.
- Reads opcode, optional extension byte and immediate bytes from the memory bus at PC, querying the combinational instruction decoder after each byte.
- Presents one assembled instruction per valid/ready handshake to the execute stage.
- Supports synchronous PC redirect for branches and interrupts.

Parameters:
- ADDR_W, 24, width of PC and bus address.
- RESET_PC, 24'h000000, PC value loaded at reset.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset_n  input  1  synchronous active-low reset.
- bus_addr  output  ADDR_W  fetch address (current PC).
- bus_req  output  1  read request.
- bus_ack  input  1  read complete; bus_data valid this cycle.
- bus_data  input  8  read byte.
- dec_opcode  output  8  opcode presented to decoder.
- dec_opext  output  8  extension byte presented to decoder.
- dec_need_opext  input  1  decoder: opcode takes an extension byte.
- dec_need_imm  input  1  decoder: immediate follows.
- dec_imm_size  input  1  decoder: 0 = imm8, 1 = imm16.
- pc_load  input  1  redirect strobe.
- pc_new  input  ADDR_W  redirect target.
- instr_valid  output  1  assembled instruction available.
- instr_ready  input  1  execute stage accepts.
- instr_opcode  output  8  opcode.
- instr_opext  output  8  extension byte; 0 if none.
- instr_imm  output  16  immediate, little-endian; upper byte 0 for imm8.
- instr_len  output  3  total bytes, 1..4.

Behaviour:
- Reset (reset_n low at clk edge):
  - pc=RESET_PC; state=FETCH_OP.
  - bus_req=0 during the reset cycle.
  - instr_valid=0; instr_opcode/opext/imm=0; instr_len=0.
  - First request is in the cycle after reset release.
- States: FETCH_OP, FETCH_EXT, FETCH_IMM0, FETCH_IMM1, HOLD.
- Bus rules:
  - bus_req=1 in every FETCH_* state; bus_addr=pc stays stable until bus_ack.
  - A byte is captured on the cycle bus_req & bus_ack; pc increments by 1 on that edge, wrapping modulo 2^ADDR_W.
  - Zero-wait ack gives one byte per cycle.
- Decoder drive:
  - dec_opcode = bus_data in FETCH_OP, else the registered opcode.
  - dec_opext = bus_data in FETCH_EXT, else the registered opext (0 when unused).
  - The next-state decision is made in the ack cycle, so the decoder adds no cycles.
- Transitions on ack:
  - FETCH_OP -> FETCH_EXT if dec_need_opext.
  - FETCH_OP -> FETCH_IMM0 if dec_need_imm.
  - FETCH_OP -> HOLD otherwise.
  - FETCH_EXT -> FETCH_IMM0 if dec_need_imm, else HOLD.
  - FETCH_IMM0 -> FETCH_IMM1 if the imm_size latched at the decision is 1, else HOLD.
  - FETCH_IMM1 -> HOLD.
- Output handshake:
  - instr_valid=1 exactly in HOLD; all instr_* stay stable while valid & !ready.
  - On valid & ready: state=FETCH_OP next cycle, instr_valid=0.
  - No prefetch: bus_req=0 in HOLD.
  - Minimum latency, zero-wait bus: a 1-byte instruction is valid 1 cycle after its opcode ack.
- instr_len: 1 + need_opext + (need_imm ? 1 + imm_size : 0).
- Redirect:
  - pc_load has priority over everything except reset, in any state.
  - Next edge: pc=pc_new, state=FETCH_OP, instr_valid=0.
  - A bus_ack in the same cycle is discarded; a held instruction is discarded even if ready=1 that cycle.
  - bus_req continues (new address) the next cycle.
- Reset mid-fetch: an outstanding ack is ignored; the bus must tolerate bus_req dropping.

Optional Feature:
- Macro INSTR_FETCH_PC_OUT_EN.
- When defined: adds output instr_pc [ADDR_W] = address of the instruction's opcode byte.
  - Captured on the opcode ack; stable while instr_valid.
  - Reset value RESET_PC.
  - Used for relative branches and debug trace.
- When undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package instr_fetch_pkg: state enum (FETCH_OP..HOLD), ADDR_W default, INSTR_LEN_MAX=4.
- No sub-module; the decoder stays external and connects via the dec_* ports.
- The bench uses a table-driven decoder stub.

Test Plan:
- Reset: reset_n=0 for 2 cycles -> bus_req=0, instr_valid=0; after release bus_req=1, bus_addr=RESET_PC.
- Zero-wait byte 0x00, stub reports no ext/imm -> instr_valid one cycle after ack, opcode=0x00, len=1; ready=1 -> next fetch at RESET_PC+1.
- Bytes 0xCE,0x10,0x34,0x12, stub need_opext=1 then imm16 -> opext=0x10, imm=0x1234, len=4, pc advanced by 4.
- Ack delayed 3 cycles per byte with instr_ready=0 for 5 cycles -> bus_addr stable while waiting; instr_* stable during hold; one instruction delivered.
- pc_load with pc_new=0x001200 in the same cycle as an imm0 ack -> byte discarded, no instr_valid, next bus_addr=0x001200.
- PC=0xFFFFFF, 1-byte instruction -> next bus_addr=0x000000.
